// File: rtl/reg_file.sv
// 32 x 32-bit register file with two combinational read ports, one writeback port and a
// per-register pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module reg_file (
  input  logic        clk_in,
  input  logic        n_rst_in,
  input  logic [4:0]  WB_reg_write_address_in,
  input  logic [31:0] WB_reg_write_data_in,
  input  logic        WB_ctrl_reg_write_in,
  input  logic [4:0]  ID_rs_address_in,
  input  logic [4:0]  ID_rt_address_in,
  input  logic        ID_sb_set_in,
  input  logic [4:0]  ID_sb_set_address_in,
  input  logic        ID_sb_flush_in,
  output logic [31:0] RF_rs_data_out,
  output logic [31:0] RF_rt_data_out,
  output logic        RF_rs_busy_out,
  output logic        RF_rt_busy_out
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] sb_q;
  logic [31:0] sb_d;
  logic        wr_en;

  assign wr_en = WB_ctrl_reg_write_in && (WB_reg_write_address_in != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WB_reg_write_address_in] = WB_reg_write_data_in;
    end
    regs_d[0] = '0;
  end

  // A new pending write outranks flush, which outranks the writeback clear.
  always_comb begin
    sb_d = sb_q;
    for (int i = 1; i < 32; i++) begin
      if (ID_sb_set_in && (ID_sb_set_address_in == 5'(i))) begin
        sb_d[i] = 1'b1;
      end else if (ID_sb_flush_in) begin
        sb_d[i] = 1'b0;
      end else if (WB_ctrl_reg_write_in && (WB_reg_write_address_in == 5'(i))) begin
        sb_d[i] = 1'b0;
      end
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_in or negedge n_rst_in) begin
    if (!n_rst_in) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      sb_q <= '0;
    end else begin
      regs_q <= regs_d;
      sb_q   <= sb_d;
    end
  end

  // Outputs are gated by reset so a bypassed write cannot leak out while in reset.
  function automatic logic [31:0] read_data(input logic [4:0] addr);
    logic [31:0] val;
    val = '0;
    if (n_rst_in && (addr != 5'd0)) begin
      val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WB_reg_write_address_in == addr)) begin
        val = WB_reg_write_data_in;
      end
`endif
    end
    return val;
  endfunction

  function automatic logic read_busy(input logic [4:0] addr);
    logic val;
    val = 1'b0;
    if (n_rst_in && (addr != 5'd0)) begin
      val = sb_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WB_reg_write_address_in == addr)) begin
        val = 1'b0;
      end
`endif
    end
    return val;
  endfunction

  always_comb begin
    RF_rs_data_out = read_data(ID_rs_address_in);
    RF_rt_data_out = read_data(ID_rt_address_in);
    RF_rs_busy_out = read_busy(ID_rs_address_in);
    RF_rt_busy_out = read_busy(ID_rt_address_in);
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a behavioural model predicts each cycle's read-port values,
// which are queued when stimulus is driven and compared when the outputs settle.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic        sb_flush;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_busy;
  logic        rt_busy;

  always #5 clk = ~clk;

  reg_file dut (
    .clk_in                  (clk),
    .n_rst_in                (n_rst),
    .WB_reg_write_address_in (wa),
    .WB_reg_write_data_in    (wd),
    .WB_ctrl_reg_write_in    (we),
    .ID_rs_address_in        (rs),
    .ID_rt_address_in        (rt),
    .ID_sb_set_in            (sb_set),
    .ID_sb_set_address_in    (sb_addr),
    .ID_sb_flush_in          (sb_flush),
    .RF_rs_data_out          (rs_data),
    .RF_rt_data_out          (rt_data),
    .RF_rs_busy_out          (rs_busy),
    .RF_rt_busy_out          (rt_busy)
  );

  typedef struct {
    string       tag;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic        rs_b;
    logic        rt_b;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_sb   [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_data(input logic [4:0] a);
    if (!n_rst || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 5'd0 && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_busy(input logic [4:0] a);
    if (!n_rst || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa != 5'd0 && wa == a) return 1'b0;
`endif
    return m_sb[a];
  endfunction

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag  = tag;
    e.rs_d = m_data(rs);
    e.rt_d = m_data(rt);
    e.rs_b = m_busy(rs);
    e.rt_b = m_busy(rt);
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".rs_data"}, rs_data, e.rs_d);
    check({e.tag, ".rt_data"}, rt_data, e.rt_d);
    check({e.tag, ".rs_busy"}, {31'd0, rs_busy}, {31'd0, e.rs_b});
    check({e.tag, ".rt_busy"}, {31'd0, rt_busy}, {31'd0, e.rt_b});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_sb[i]   = 1'b0;
    end
  endtask

  // Advances the model across one rising edge using the inputs held during that edge.
  task automatic model_edge();
    if (!n_rst) return;
    for (int i = 1; i < 32; i++) begin
      if (sb_set && sb_addr == i[4:0])    m_sb[i] = 1'b1;
      else if (sb_flush)                  m_sb[i] = 1'b0;
      else if (we && wa == i[4:0])        m_sb[i] = 1'b0;
    end
    if (we && wa != 5'd0) m_regs[wa] = wd;
  endtask

  task automatic drive(input logic we_i, input logic [4:0] wa_i, input logic [31:0] wd_i,
                       input logic [4:0] rs_i, input logic [4:0] rt_i,
                       input logic set_i, input logic [4:0] sa_i, input logic flush_i);
    we = we_i; wa = wa_i; wd = wd_i; rs = rs_i; rt = rt_i;
    sb_set = set_i; sb_addr = sa_i; sb_flush = flush_i;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input string tag, input logic we_i, input logic [4:0] wa_i,
                      input logic [31:0] wd_i, input logic [4:0] rs_i, input logic [4:0] rt_i,
                      input logic set_i, input logic [4:0] sa_i, input logic flush_i);
    drive(we_i, wa_i, wd_i, rs_i, rt_i, set_i, sa_i, flush_i);
    push_exp(tag);
    @(negedge clk);
    pop_cmp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    n_rst = 1'b0;
    drive(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd9, 1'b1, 5'd9, 1'b0);
    #2;
    push_exp("reset_init");
    #1;
    pop_cmp();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    step("post_reset", 1'b0, 5'd0, 32'd0, 5'd5, 5'd9, 1'b0, 5'd0, 1'b0);
    step("wr_r7",      1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
    step("rd_r7",      1'b1, 5'd0, 32'hFFFF_FFFF, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    step("rd_r0",      1'b0, 5'd0, 32'd0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0);
    step("byp_r3",     1'b1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0);
    step("after_r3",   1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
    step("set_r9",     1'b0, 5'd0, 32'd0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
    step("busy_r9",    1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
    step("wb_r9",      1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    step("clr_r9",     1'b0, 5'd0, 32'd0, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
    step("set_wb_r4",  1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0);
    step("busy_r4",    1'b0, 5'd0, 32'd0, 5'd4, 5'd4, 1'b0, 5'd0, 1'b0);
    step("set_r2",     1'b0, 5'd0, 32'd0, 5'd2, 5'd6, 1'b1, 5'd2, 1'b0);
    step("set_r6",     1'b0, 5'd0, 32'd0, 5'd2, 5'd6, 1'b1, 5'd6, 1'b0);
    step("flush_set6", 1'b0, 5'd0, 32'd0, 5'd2, 5'd6, 1'b1, 5'd6, 1'b1);
    step("after_fl",   1'b0, 5'd0, 32'd0, 5'd2, 5'd6, 1'b0, 5'd0, 1'b0);
    step("wr_r12",     1'b1, 5'd12, 32'h0000_0C0C, 5'd12, 5'd12, 1'b1, 5'd12, 1'b0);
    step("dual_r12",   1'b0, 5'd0, 32'd0, 5'd12, 5'd12, 1'b0, 5'd0, 1'b0);
    step("set_r0",     1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    step("rd_set_r0",  1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      step("rnd",
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0));
    end

    step("wr_r5",      1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
    step("rd_r5",      1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);

    // Asynchronous reset in the middle of a cycle that also carries a write and a set.
    drive(1'b1, 5'd5, 32'h0BAD_F00D, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0);
    #2;
    n_rst = 1'b0;
    push_exp("async_rst");
    #1;
    pop_cmp();
    model_clear();
    @(posedge clk);
    #1;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    step("rst_r5",     1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0);
    step("rst_wr_r5",  1'b1, 5'd5, 32'h5555_0005, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
    step("rst_rd_r5",  1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

- 32 x 32-bit general-purpose register file: destination of the writeback stage's write interface, source of operands for decode.
- One synchronous write port driven by writeback; two combinational read ports consumed by decode.
- Per-register pending-write scoreboard: decode marks a destination busy when it issues a long-latency write (load); the matching writeback clears it. Decode stalls on busy operands.
- Register 0 is hardwired to zero and is never busy.

## Interface

Parameters: none (fixed 32 registers, 32-bit data, 5-bit addresses).

- clk_in  input  1  clock, rising edge
- n_rst_in  input  1  asynchronous active-low reset
- WB_reg_write_address_in  input  5  writeback destination register
- WB_reg_write_data_in  input  32  writeback data
- WB_ctrl_reg_write_in  input  1  writeback write enable
- ID_rs_address_in  input  5  read port A address
- ID_rt_address_in  input  5  read port B address
- ID_sb_set_in  input  1  mark ID_sb_set_address_in pending
- ID_sb_set_address_in  input  5  register to mark pending
- ID_sb_flush_in  input  1  clear all pending bits (pipeline flush)
- RF_rs_data_out  output  32  read port A data
- RF_rt_data_out  output  32  read port B data
- RF_rs_busy_out  output  1  read port A register has a pending write
- RF_rt_busy_out  output  1  read port B register has a pending write

## Operation

- Storage: regs[1..31], 32 bits each; scoreboard sb[1..31], 1 bit each. Index 0 has no storage: reads return 0, busy returns 0.
- Write: on a rising edge with WB_ctrl_reg_write_in=1 and address!=0, regs[address] <= data. Writes to address 0 are discarded.
- Scoreboard next state, per register i (1..31), applied in priority order:
  1. Set: ID_sb_set_in=1 and ID_sb_set_address_in==i -> sb[i]<=1 (highest priority; a new pending write outranks flush and clear in the same cycle).
  2. Flush: ID_sb_flush_in=1 -> sb[i]<=0.
  3. Clear: WB_ctrl_reg_write_in=1 and WB_reg_write_address_in==i -> sb[i]<=0.
  4. Otherwise hold.
- Set with address 0 is ignored.
- Reads: combinational from the addresses. The read mux selects regs or bypass data, and the raw or bypassed busy bit (see Configuration).

## Timing

- Reset (n_rst_in=0, asynchronous): all regs=0, all sb=0. While in reset, every data output is 0 and every busy output is 0 regardless of addresses. Reset deassertion is sampled at the next rising edge.
- Reset asserted mid-operation discards any write or set in that cycle.
- Write latency: data is stored at the edge. Without bypass it is visible on the read ports the cycle after the edge; with bypass it is visible in the same cycle it is presented.
- The busy bit is set at the edge where the set is sampled; RF_*_busy_out is 1 from the next cycle.
- Both read ports may address the same register; both return identical data and busy.
- There is no handshake; writeback presents at most one write per cycle.

## Configuration

- REGFILE_BYPASS_EN defined:
  - Data bypass: when WB_ctrl_reg_write_in=1, the write address is nonzero and equals a read address, that port returns WB_reg_write_data_in in the same cycle.
  - Busy bypass: that port's busy output is forced to 0 in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - Read ports return stored values only.
  - Busy outputs show raw sb bits, so a write and a read of the same register in one cycle return the old value with busy still 1. Decode then stalls one extra cycle.

## Test plan

- Reset: drive n_rst_in=0 mid-run after writing r5=0xDEADBEEF -> RF_rs_data_out=0 for rs=5 immediately (asynchronous), busy outputs 0.
- Write then read: write r7=0x12345678 at edge N; rs=7 -> 0x12345678 from cycle N+1. A write of 0xFFFFFFFF to r0 -> rs=0 still reads 0.
- Bypass, same cycle: write r3=0xA5A5A5A5 while rt=3 -> with REGFILE_BYPASS_EN, RF_rt_data_out=0xA5A5A5A5 that cycle; without it, the old value (0) that cycle and 0xA5A5A5A5 the next.
- Scoreboard: set r9 at edge N -> RF_rs_busy_out=1 for rs=9 from N+1. Writeback to r9 at edge M -> busy 0 from M+1. With bypass, busy is also 0 during the write cycle M.
- Simultaneous events:
  - Set r4 and writeback to r4 in the same cycle -> sb[4]=1 afterward.
  - Flush with r2 and r6 busy plus a set of r6 in the same cycle -> afterward sb[2]=0, sb[6]=1.
- Dual read: rs=rt=12 after writing r12=0x00000C0C -> both ports read 0x00000C0C with identical busy.
